// File: rtl/dds_profile_sequencer.sv
// dds_profile_sequencer: plays a stored list of modulation profiles into
// dds_modulator. Each profile is loaded, enabled for its dwell time and then
// held in reset for a fixed gap before the next profile is loaded.
module dds_profile_sequencer #(
    parameter int unsigned NUM_PROFILES = 8,
    parameter int unsigned DWELL_BITS   = 24,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned ENABLE_BIT   = 0,
    parameter int unsigned DEBUG_BIT    = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wr_en_i,
    input  logic [$clog2(NUM_PROFILES)-1:0]   wr_prof_i,
    input  logic [2:0]                        wr_field_i,
    input  logic [31:0]                       wr_data_i,
    input  logic [$clog2(NUM_PROFILES):0]     num_profiles_i,
    input  logic                              loop_i,
    input  logic                              debug_i,
    input  logic                              start_i,
    input  logic                              stop_i,
    output logic [31:0]                       config_reg_0_o,
    output logic [31:0]                       config_reg_1_o,
    output logic [31:0]                       config_reg_2_o,
    output logic [31:0]                       config_reg_3_o,
    output logic [31:0]                       config_reg_4_o,
    output logic [31:0]                       config_reg_5_o,
    output logic                              mod_rst_o,
    output logic                              busy_o,
    output logic [$clog2(NUM_PROFILES)-1:0]   profile_idx_o,
    output logic                              done_o
);

    localparam int unsigned PW = $clog2(NUM_PROFILES);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [31:0]           mode_tbl  [NUM_PROFILES];
    logic [31:0]           cfg_tbl   [NUM_PROFILES][4];
    logic [DWELL_BITS-1:0] dwell_tbl [NUM_PROFILES];

    logic [1:0]            state_q, state_d;
    logic [DWELL_BITS-1:0] cnt_q, cnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic [PW-1:0]         idx_d;
    logic [31:0]           cfg0_d, cfg1_d, cfg2_d, cfg3_d, cfg4_d, cfg5_d;
    logic                  done_d;
    logic [PW:0]           num_eff_c;

    // Requested profile count clamped to the table depth
    assign num_eff_c = (num_profiles_i > (PW+1)'(NUM_PROFILES)) ? (PW+1)'(NUM_PROFILES)
                                                                : num_profiles_i;

    // Profile table; writes accepted in every state, cleared by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_PROFILES; i++) begin
                mode_tbl[i]  <= '0;
                dwell_tbl[i] <= '0;
                for (int unsigned j = 0; j < 4; j++) cfg_tbl[i][j] <= '0;
            end
        end else if (wr_en_i) begin
            case (wr_field_i)
                3'd0:                   mode_tbl[wr_prof_i] <= wr_data_i;
                3'd1, 3'd2, 3'd3, 3'd4: cfg_tbl[wr_prof_i][2'(wr_field_i - 3'd1)] <= wr_data_i;
                3'd5:                   dwell_tbl[wr_prof_i] <= wr_data_i[DWELL_BITS-1:0];
                default: ;
            endcase
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        idx_d   = profile_idx_o;
        cfg1_d  = config_reg_1_o;
        cfg2_d  = config_reg_2_o;
        cfg3_d  = config_reg_3_o;
        cfg4_d  = config_reg_4_o;
        cfg5_d  = config_reg_5_o;
        done_d  = 1'b0;
        cfg0_d  = '0;
        if (stop_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !stop_i && (num_profiles_i != '0)) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end
                end
                S_LOAD: begin
                    state_d = S_RUN;
                    cfg1_d  = mode_tbl[profile_idx_o];
                    cfg2_d  = cfg_tbl[profile_idx_o][0];
                    cfg3_d  = cfg_tbl[profile_idx_o][1];
                    cfg4_d  = cfg_tbl[profile_idx_o][2];
                    cfg5_d  = cfg_tbl[profile_idx_o][3];
                    cnt_d   = (dwell_tbl[profile_idx_o] == '0) ? DWELL_BITS'(1)
                                                               : dwell_tbl[profile_idx_o];
                end
                S_RUN: begin
                    if (cnt_q <= DWELL_BITS'(1)) begin
                        state_d = S_GAP;
                        gcnt_d  = GW'(GAP_CYCLES);
                    end else begin
                        cnt_d = cnt_q - DWELL_BITS'(1);
                    end
                end
                S_GAP: begin
                    if (gcnt_q <= GW'(1)) begin
                        if (({1'b0, profile_idx_o} + (PW+1)'(1)) < num_eff_c) begin
                            idx_d   = profile_idx_o + PW'(1);
                            state_d = S_LOAD;
                        end else if (loop_i) begin
                            idx_d   = '0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gcnt_d = gcnt_q - GW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        cfg0_d[ENABLE_BIT] = (state_d == S_RUN);
        cfg0_d[DEBUG_BIT]  = debug_i;
    end

    // State and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            gcnt_q         <= '0;
            profile_idx_o  <= '0;
            config_reg_0_o <= '0;
            config_reg_1_o <= '0;
            config_reg_2_o <= '0;
            config_reg_3_o <= '0;
            config_reg_4_o <= '0;
            config_reg_5_o <= '0;
            mod_rst_o      <= 1'b1;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            gcnt_q         <= gcnt_d;
            profile_idx_o  <= idx_d;
            config_reg_0_o <= cfg0_d;
            config_reg_1_o <= cfg1_d;
            config_reg_2_o <= cfg2_d;
            config_reg_3_o <= cfg3_d;
            config_reg_4_o <= cfg4_d;
            config_reg_5_o <= cfg5_d;
            mod_rst_o      <= (state_d != S_RUN);
            busy_o         <= (state_d != S_IDLE);
            done_o         <= done_d;
        end
    end

endmodule
